// File: rtl/qbus_dma_arbiter_pkg.sv
// Shared definitions for the QBUS DMA arbiter slice:
// arbiter state encodings and QBUS address/data widths.
package qbus_dma_arbiter_pkg;

    localparam int QBUS_AW = 22;
    localparam int QBUS_DW = 16;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_OWN     = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/qbus_dma_arbiter_rr_pick.sv
// Round-robin picker: first requester after `last`, wrapping.
// Purely combinational so it can also serve interrupt arbitration.
import qbus_dma_arbiter_pkg::*;

module qbus_dma_arbiter_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   last,
    output logic [2:0]   next,
    output logic         valid
);

    logic [7:0] req_x;

    assign req_x = 8'(req);

    always_comb begin
        next  = '0;
        valid = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!valid && req_x[3'((int'(last) + k) % N)]) begin
                valid = 1'b1;
                next  = 3'((int'(last) + k) % N);
            end
        end
    end

endmodule

// File: rtl/qbus_dma_arbiter.sv
// Shares one QBUS DMA engine among NREQ controllers with
// round-robin, burst-limited ownership.
import qbus_dma_arbiter_pkg::*;

module qbus_dma_arbiter #(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                    clk,
    input  logic                    RINIT,
    input  logic [NREQ-1:0]         req_rd,
    input  logic [NREQ-1:0]         req_wr,
    input  logic [NREQ*QBUS_AW-1:0] req_tal,
    input  logic [NREQ*QBUS_DW-1:0] req_tdl,
    output logic [NREQ-1:0]         req_master,
    output logic [NREQ-1:0]         req_complete,
    output logic [NREQ-1:0]         req_nxm,
    output logic                    dma_read_req,
    output logic                    dma_write_req,
    output logic [QBUS_AW-1:0]      TAL,
    output logic [QBUS_DW-1:0]      TDL,
    input  logic                    dma_bus_master,
    input  logic                    dma_complete,
    input  logic                    dma_nxm,
    output logic                    busy,
    output logic [2:0]              owner
);

    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_t      state;
    logic [2:0]      owner_q;
    logic [2:0]      last_q;
    logic [CW-1:0]   count;
    logic [NREQ-1:0] req;
    logic [7:0]      rd_x;
    logic [7:0]      wr_x;
    logic [2:0]      pick;
    logic            pick_valid;
    logic            own;
    logic            own_rd;
    logic            own_wr;
    logic            release_now;
    logic [NREQ-1:0] sel;

    assign req  = req_rd | req_wr;
    assign rd_x = 8'(req_rd);
    assign wr_x = 8'(req_wr);

    qbus_dma_arbiter_rr_pick #(
        .N(NREQ)
    ) u_pick (
        .req  (req),
        .last (last_q),
        .next (pick),
        .valid(pick_valid)
    );

    // RINIT blanks everything at once so an aborted cycle forwards nothing
    assign own    = (state == ARB_OWN) && !RINIT;
    assign own_rd = rd_x[owner_q];
    assign own_wr = wr_x[owner_q];

    // A req drop only ends ownership once the engine has let go of the bus
    assign release_now = dma_nxm
                       | (dma_complete && count == CW'(MAX_BURST - 1))
                       | (!(own_rd | own_wr) && !dma_bus_master);

    always_comb begin
        sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            sel[i] = own && (owner_q == 3'(i));
        end
    end

    always_comb begin
        dma_read_req  = own & own_rd;
        dma_write_req = own & own_wr & ~own_rd;
        TAL           = '0;
        TDL           = '0;
        if (own) begin
            TAL = req_tal[QBUS_AW*int'(owner_q) +: QBUS_AW];
            TDL = req_tdl[QBUS_DW*int'(owner_q) +: QBUS_DW];
        end
        req_master   = dma_bus_master ? sel : '0;
        req_complete = dma_complete   ? sel : '0;
        req_nxm      = dma_nxm        ? sel : '0;
    end

    assign busy  = (state != ARB_IDLE);
    assign owner = owner_q;

    always_ff @(posedge clk) begin
        if (RINIT) begin
            state   <= ARB_IDLE;
            owner_q <= '0;
            last_q  <= 3'(NREQ - 1);
            count   <= '0;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        owner_q <= pick;
                        count   <= '0;
                        state   <= ARB_OWN;
                    end
                end
                ARB_OWN: begin
                    if (dma_complete) count <= count + 1'b1;
                    if (release_now) state <= ARB_RELEASE;
                end
                ARB_RELEASE: begin
                    last_q <= owner_q;
                    state  <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qbus_dma_arbiter.sv
// Self-checking bench for qbus_dma_arbiter: directed scenarios
// plus randomized traffic against a behavioural reference model.
module tb_qbus_dma_arbiter;

    localparam int NREQ = 4;
    localparam int MB   = 4;

    logic          clk = 1'b0;
    logic          rinit;
    logic [3:0]    req_rd, req_wr;
    logic [87:0]   req_tal;
    logic [63:0]   req_tdl;
    logic [3:0]    req_master, req_complete, req_nxm;
    logic          dma_read_req, dma_write_req;
    logic [21:0]   tal;
    logic [15:0]   tdl;
    logic          dma_bus_master, dma_complete, dma_nxm;
    logic          busy;
    logic [2:0]    owner;

    int checks   = 0;
    int failures = 0;

    qbus_dma_arbiter #(.NREQ(NREQ), .MAX_BURST(MB)) dut (
        .clk           (clk),
        .RINIT         (rinit),
        .req_rd        (req_rd),
        .req_wr        (req_wr),
        .req_tal       (req_tal),
        .req_tdl       (req_tdl),
        .req_master    (req_master),
        .req_complete  (req_complete),
        .req_nxm       (req_nxm),
        .dma_read_req  (dma_read_req),
        .dma_write_req (dma_write_req),
        .TAL           (tal),
        .TDL           (tdl),
        .dma_bus_master(dma_bus_master),
        .dma_complete  (dma_complete),
        .dma_nxm       (dma_nxm),
        .busy          (busy),
        .owner         (owner)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_data();
        for (int i = 0; i < NREQ; i++) begin
            req_tal[22*i +: 22] = 22'($urandom);
            req_tdl[16*i +: 16] = 16'($urandom);
        end
    endtask

    task automatic do_reset();
        rinit          = 1'b1;
        req_rd         = '0;
        req_wr         = '0;
        dma_bus_master = 1'b0;
        dma_complete   = 1'b0;
        dma_nxm        = 1'b0;
        randomize_data();
        tick();
        tick();
        rinit = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        rinit  = 1'b1;
        req_rd = 4'hF;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || owner !== 3'd0) begin
            failures++;
            $display("FAIL reset_state busy=%b owner=%0d need 0/0", busy, owner);
        end
        checks++;
        if ({dma_read_req, dma_write_req, tal, tdl} !== '0 ||
            {req_master, req_complete, req_nxm} !== '0) begin
            failures++;
            $display("FAIL reset_outputs rd=%b wr=%b tal=%h need all 0",
                     dma_read_req, dma_write_req, tal);
        end
        req_rd = '0;
        rinit  = 1'b0;
        tick();
    endtask

    task automatic test_single_grant();
        do_reset();
        req_rd = 4'b0100;
        #1;
        checks++;
        if (busy !== 1'b0 || dma_read_req !== 1'b0) begin
            failures++;
            $display("FAIL grant_idle busy=%b rd=%b need 0/0", busy, dma_read_req);
        end
        tick();
        checks++;
        if (owner !== 3'd2 || busy !== 1'b1 || dma_read_req !== 1'b1) begin
            failures++;
            $display("FAIL grant_own owner=%0d busy=%b rd=%b need 2/1/1",
                     owner, busy, dma_read_req);
        end
        checks++;
        if (tal !== req_tal[44 +: 22] || tdl !== req_tdl[32 +: 16]) begin
            failures++;
            $display("FAIL grant_mux tal=%h tdl=%h need %h %h",
                     tal, tdl, req_tal[44 +: 22], req_tdl[32 +: 16]);
        end
        dma_bus_master = 1'b1;
        #1;
        checks++;
        if (req_master !== 4'b0100) begin
            failures++;
            $display("FAIL grant_master got=%b need 0100", req_master);
        end
        dma_bus_master = 1'b0;
        req_rd         = '0;
        tick();
        checks++;
        if (busy !== 1'b1 || dma_read_req !== 1'b0 || tal !== '0) begin
            failures++;
            $display("FAIL grant_release busy=%b rd=%b tal=%h need 1/0/0",
                     busy, dma_read_req, tal);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL grant_idle_again busy=%b need 0", busy);
        end
    endtask

    task automatic test_fairness();
        int seq[$];
        int phase;
        int gap;
        bit seen;
        do_reset();
        req_rd = 4'b0011;
        phase  = 0;
        gap    = 0;
        seen   = 1'b0;
        for (int cyc = 0; cyc < 200 && seq.size() < 12; cyc++) begin
            if (dma_read_req) begin
                if (seen && gap > 0) begin
                    checks++;
                    if (gap < 1 || gap > 2) begin
                        failures++;
                        $display("FAIL fair_gap got=%0d need 1..2", gap);
                    end
                end
                gap            = 0;
                seen           = 1'b1;
                phase++;
                dma_bus_master = 1'b1;
                dma_complete   = (phase % 3 == 0);
            end else begin
                if (seen) gap++;
                phase          = 0;
                dma_bus_master = 1'b0;
                dma_complete   = 1'b0;
            end
            #1;
            if (dma_complete) begin
                int exp_o;
                exp_o = (seq.size() / MB) % 2;
                checks++;
                if (req_complete !== (4'b0001 << exp_o)) begin
                    failures++;
                    $display("FAIL fair_complete word=%0d got=%b need owner %0d",
                             seq.size(), req_complete, exp_o);
                end
                seq.push_back(int'(owner));
            end
            tick();
        end
        dma_complete   = 1'b0;
        dma_bus_master = 1'b0;
        checks++;
        if (seq.size() != 12) begin
            failures++;
            $display("FAIL fair_budget words=%0d need 12", seq.size());
        end
        req_rd = '0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_nxm();
        do_reset();
        req_wr = 4'b0110;
        tick();
        checks++;
        if (owner !== 3'd1 || dma_write_req !== 1'b1) begin
            failures++;
            $display("FAIL nxm_grant owner=%0d wr=%b need 1/1", owner, dma_write_req);
        end
        dma_bus_master = 1'b1;
        dma_complete   = 1'b1;
        #1;
        checks++;
        if (req_complete !== 4'b0010) begin
            failures++;
            $display("FAIL nxm_word1 got=%b need 0010", req_complete);
        end
        tick();
        dma_complete = 1'b0;
        dma_nxm      = 1'b1;
        #1;
        checks++;
        if (req_nxm !== 4'b0010) begin
            failures++;
            $display("FAIL nxm_pulse got=%b need 0010", req_nxm);
        end
        tick();
        dma_nxm        = 1'b0;
        dma_bus_master = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1 || dma_write_req !== 1'b0 || req_nxm !== '0) begin
            failures++;
            $display("FAIL nxm_release busy=%b wr=%b nxm=%b need 1/0/0",
                     busy, dma_write_req, req_nxm);
        end
        tick();
        tick();
        checks++;
        if (owner !== 3'd2 || dma_write_req !== 1'b1) begin
            failures++;
            $display("FAIL nxm_next owner=%0d wr=%b need 2/1", owner, dma_write_req);
        end
        req_wr = '0;
        tick();
        tick();
    endtask

    task automatic test_early_drop();
        do_reset();
        req_wr = 4'b0001;
        tick();
        dma_bus_master = 1'b1;
        for (int w = 0; w < 3; w++) begin
            dma_complete = 1'b1;
            tick();
            dma_complete = 1'b0;
            tick();
        end
        checks++;
        if (busy !== 1'b1 || owner !== 3'd0 || dma_write_req !== 1'b1) begin
            failures++;
            $display("FAIL drop_still_own busy=%b owner=%0d wr=%b need 1/0/1",
                     busy, owner, dma_write_req);
        end
        req_wr         = '0;
        dma_bus_master = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b1 || dma_write_req !== 1'b0) begin
            failures++;
            $display("FAIL drop_release busy=%b wr=%b need 1/0", busy, dma_write_req);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL drop_idle busy=%b need 0", busy);
        end
    endtask

    task automatic test_rinit_abort();
        do_reset();
        req_rd = 4'b0010;
        tick();
        dma_bus_master = 1'b1;
        tick();
        rinit        = 1'b1;
        dma_complete = 1'b1;
        #1;
        checks++;
        if (req_complete !== '0 || req_master !== '0) begin
            failures++;
            $display("FAIL rinit_same_cycle cmp=%b mst=%b need 0/0",
                     req_complete, req_master);
        end
        tick();
        dma_complete   = 1'b0;
        dma_bus_master = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || dma_read_req !== 1'b0 || tal !== '0 ||
            req_master !== '0) begin
            failures++;
            $display("FAIL rinit_after busy=%b rd=%b tal=%h need 0", busy,
                     dma_read_req, tal);
        end
        rinit  = 1'b0;
        req_rd = 4'b1111;
        tick();
        checks++;
        if (owner !== 3'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rinit_first owner=%0d busy=%b need 0/1", owner, busy);
        end
    endtask

    task automatic test_read_wins();
        do_reset();
        req_rd = 4'b1000;
        req_wr = 4'b1000;
        tick();
        checks++;
        if (dma_read_req !== 1'b1 || dma_write_req !== 1'b0 ||
            tal !== req_tal[66 +: 22]) begin
            failures++;
            $display("FAIL read_wins rd=%b wr=%b tal=%h need 1/0/%h",
                     dma_read_req, dma_write_req, tal, req_tal[66 +: 22]);
        end
    endtask

    task automatic test_random();
        int  m_owner;
        bit  m_rel;
        int  m_last;
        int  m_words;
        logic       e_rd, e_wr, e_busy;
        logic [21:0] e_tal;
        logic [15:0] e_tdl;
        logic [3:0]  e_mst, e_cmp, e_nxm;
        do_reset();
        m_owner = -1;
        m_rel   = 1'b0;
        m_last  = NREQ - 1;
        m_words = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            rinit = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 3) == 0) begin
                req_rd = 4'($urandom) & 4'($urandom);
                req_wr = 4'($urandom) & 4'($urandom);
            end
            if ($urandom_range(0, 7) == 0) randomize_data();
            dma_bus_master = 1'($urandom_range(0, 1));
            dma_complete   = dma_bus_master & ($urandom_range(0, 2) == 0);
            dma_nxm        = ($urandom_range(0, 15) == 0);
            #1;
            e_rd = 0; e_wr = 0; e_tal = '0; e_tdl = '0;
            e_mst = '0; e_cmp = '0; e_nxm = '0;
            e_busy = (m_owner >= 0) || m_rel;
            if (!rinit && m_owner >= 0) begin
                e_rd  = req_rd[m_owner];
                e_wr  = req_wr[m_owner] & ~req_rd[m_owner];
                e_tal = req_tal[22*m_owner +: 22];
                e_tdl = req_tdl[16*m_owner +: 16];
                if (dma_bus_master) e_mst = 4'b0001 << m_owner;
                if (dma_complete)   e_cmp = 4'b0001 << m_owner;
                if (dma_nxm)        e_nxm = 4'b0001 << m_owner;
            end
            checks++;
            if (dma_read_req !== e_rd || dma_write_req !== e_wr || busy !== e_busy) begin
                failures++;
                $display("FAIL rand_ctl cyc=%0d rd=%b wr=%b busy=%b need %b %b %b",
                         cyc, dma_read_req, dma_write_req, busy, e_rd, e_wr, e_busy);
            end
            checks++;
            if (tal !== e_tal || tdl !== e_tdl) begin
                failures++;
                $display("FAIL rand_mux cyc=%0d tal=%h tdl=%h need %h %h",
                         cyc, tal, tdl, e_tal, e_tdl);
            end
            checks++;
            if (req_master !== e_mst || req_complete !== e_cmp || req_nxm !== e_nxm) begin
                failures++;
                $display("FAIL rand_route cyc=%0d m=%b c=%b n=%b need %b %b %b",
                         cyc, req_master, req_complete, req_nxm, e_mst, e_cmp, e_nxm);
            end
            if (!rinit && m_owner >= 0) begin
                checks++;
                if (owner !== 3'(m_owner)) begin
                    failures++;
                    $display("FAIL rand_owner cyc=%0d got=%0d need %0d",
                             cyc, owner, m_owner);
                end
            end
            if (rinit) begin
                m_owner = -1;
                m_rel   = 1'b0;
                m_last  = NREQ - 1;
            end else if (m_owner >= 0) begin
                if (dma_complete) m_words++;
                if (dma_nxm || m_words == MB ||
                    (!(req_rd[m_owner] | req_wr[m_owner]) && !dma_bus_master)) begin
                    m_last  = m_owner;
                    m_owner = -1;
                    m_rel   = 1'b1;
                end
            end else if (m_rel) begin
                m_rel = 1'b0;
            end else begin
                for (int j = 1; j <= NREQ; j++) begin
                    int idx;
                    idx = (m_last + j) % NREQ;
                    if (m_owner < 0 && (req_rd[idx] | req_wr[idx])) begin
                        m_owner = idx;
                        m_words = 0;
                    end
                end
            end
            tick();
        end
        rinit = 1'b0;
    endtask

    initial begin
        rinit          = 1'b1;
        req_rd         = '0;
        req_wr         = '0;
        req_tal        = '0;
        req_tdl        = '0;
        dma_bus_master = 1'b0;
        dma_complete   = 1'b0;
        dma_nxm        = 1'b0;
        test_reset();
        test_single_grant();
        test_fairness();
        test_nxm();
        test_early_drop();
        test_rinit_abort();
        test_read_wins();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
